// File: rtl/fetch_ctrl.sv
// Purpose : instruction-fetch PC controller, one outstanding imem request, one-entry decode output register.
// Latency : redirect in N with zero-wait imem -> instr_valid_o with instr_pc_o = target in N+3; steady state 1 instr / 2 cycles.
// Backpr. : stall_i holds the output register and blocks new requests while it is full; redirects override stall_i.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   branch_taken_i/jump_i redirect request from execute, target on redirect_target_i
//   stall_i               decode cannot accept instr_o this cycle
//   imem_*                req/gnt/rvalid instruction-memory interface (addr = current PC)
//   instr_valid_o/instr_o/instr_pc_o  fetched instruction register for decode
//   flush_o               one-cycle pulse the cycle after a redirect
//   misalign_o            (only with FETCH_MISALIGN_CHK_EN) pulse when a misaligned target halts fetch
//
// Optional feature macro: FETCH_MISALIGN_CHK_EN. When undefined the low two target bits are forced to 00.

module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        branch_taken_i,
    input  logic        jump_i,
    input  logic [31:0] redirect_target_i,
    input  logic        stall_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
`ifdef FETCH_MISALIGN_CHK_EN
    output logic        misalign_o,
`endif
    output logic        flush_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_DRAIN
`ifdef FETCH_MISALIGN_CHK_EN
        , S_HALT
`endif
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        instr_valid_q, instr_valid_d;
    logic        flush_q, flush_d;
    logic        req;
    logic        redirect;
    logic        bad_target;
`ifdef FETCH_MISALIGN_CHK_EN
    logic        misalign_q, misalign_d;
`else
    // Target bits [1:0] are deliberately dropped in this build.
    logic        unused_tgt_lsbs;
    assign unused_tgt_lsbs = ^redirect_target_i[1:0];
`endif

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        flush_d       = 1'b0;
        req           = 1'b0;
        redirect      = (branch_taken_i | jump_i) && (state_q != S_IDLE);
        bad_target    = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
        misalign_d    = 1'b0;
        // A halted fetch unit no longer listens to execute.
        if (state_q == S_HALT) begin
            redirect = 1'b0;
        end
        bad_target = redirect && (redirect_target_i[1:0] != 2'b00);
`endif

        // Decode consumes the held instruction.
        if (instr_valid_q && !stall_i) begin
            instr_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                // Only issue when the output register will be free by the time rvalid can arrive.
                req = ~(instr_valid_q & stall_i);
                if (req && imem_gnt_i) begin
                    state_d = redirect ? S_DRAIN : S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid_i) begin
                    state_d = S_FETCH;
                    if (!redirect) begin
                        instr_d       = imem_rdata_i;
                        instr_pc_d    = pc_q;
                        instr_valid_d = 1'b1;
                        pc_d          = pc_q + 32'd4;
                    end
                end else if (redirect) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // A response arriving together with a new redirect still retires the stale request.
                if (imem_rvalid_i) begin
                    state_d = S_FETCH;
                end
            end
`ifdef FETCH_MISALIGN_CHK_EN
            S_HALT: instr_valid_d = 1'b0;
`endif
            default: state_d = S_IDLE;
        endcase

        if (redirect) begin
            flush_d       = 1'b1;
            instr_valid_d = 1'b0;
            pc_d          = {redirect_target_i[31:2], 2'b00};
        end

`ifdef FETCH_MISALIGN_CHK_EN
        if (bad_target) begin
            misalign_d = 1'b1;
            pc_d       = pc_q;
            state_d    = S_HALT;
        end
`else
        bad_target = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= 32'h0;
            instr_pc_q    <= 32'h0;
            instr_valid_q <= 1'b0;
            flush_q       <= 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
            misalign_q    <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            flush_q       <= flush_d;
`ifdef FETCH_MISALIGN_CHK_EN
            misalign_q    <= misalign_d;
`endif
        end
    end

    assign imem_req_o    = req;
    assign imem_addr_o   = pc_q;
    assign instr_valid_o = instr_valid_q;
    assign instr_o       = instr_q;
    assign instr_pc_o    = instr_pc_q;
    assign flush_o       = flush_q;
`ifdef FETCH_MISALIGN_CHK_EN
    assign misalign_o    = misalign_q;
`endif

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch PC controller. It consumes the branch outcome and the redirect target from execute, and drives the PC request into instruction memory.
- Single outstanding imem request using a req/gnt/rvalid handshake.
- Holds one fetched instruction in an output register for decode, with stall backpressure.
- Squashes wrong-path instructions and stale in-flight responses on every redirect.

Parameters:
- RESET_PC, 32'h0000_0000, PC value fetched first after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- branch_taken_i  in  1  taken B-type branch from execute
- jump_i  in  1  JAL/JALR from execute
- redirect_target_i  in  32  target PC, valid when branch_taken_i|jump_i
- stall_i  in  1  decode cannot accept instr this cycle
- imem_req_o  out  1  fetch request
- imem_addr_o  out  32  fetch address (current PC)
- imem_gnt_i  in  1  request accepted
- imem_rvalid_i  in  1  response valid; at least 1 cycle after gnt
- imem_rdata_i  in  32  response instruction
- instr_valid_o  out  1  output register holds a valid instruction
- instr_o  out  32  fetched instruction
- instr_pc_o  out  32  PC of instr_o
- flush_o  out  1  one-cycle pulse, cycle after redirect

Behaviour:
- Reset values:
  - pc = RESET_PC; state = IDLE.
  - imem_req_o, instr_valid_o and flush_o are 0.
  - instr_o and instr_pc_o are 0.
- Redirect definition: redirect = branch_taken_i | jump_i, sampled every cycle in every state except IDLE (ignored in IDLE).
- States:
  - IDLE: one cycle after reset release, then FETCH.
  - FETCH:
    - imem_req_o = ~(instr_valid_o & stall_i).
    - imem_addr_o = pc.
    - req & gnt -> WAIT.
  - WAIT:
    - Request outstanding, req = 0.
    - On rvalid: instr_o <= rdata, instr_pc_o <= pc, instr_valid_o <= 1, pc <= pc+4, next state FETCH.
  - DRAIN:
    - Stale request outstanding, req = 0.
    - On rvalid: response dropped, next state FETCH; pc already holds the target.
- Output register:
  - Cleared when instr_valid_o & ~stall_i (consumed).
  - Held while stall_i.
  - Issue rule guarantees it is empty whenever rvalid arrives.
- Redirect in cycle N:
  - pc <= {redirect_target_i[31:2],2'b00}.
  - instr_valid_o <= 0.
  - flush_o = 1 in N+1.
  - From FETCH without gnt: stay FETCH. imem_addr_o = target in N+1, with req held. imem must tolerate an address change while ungranted.
  - From FETCH with gnt in N: -> DRAIN.
  - From WAIT without rvalid: -> DRAIN.
  - From WAIT with rvalid in N: response dropped, -> FETCH.
  - From DRAIN: target updated, stay DRAIN (latest redirect wins).
  - Redirect overrides stall_i.
- Latency: redirect at N, zero-wait memory (gnt in N+1, rvalid in N+2) -> instr_valid_o=1 with instr_pc_o=target in N+3.
- Steady state, zero-wait memory, no stall: one instruction every 2 cycles (single outstanding).
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC+4 wraps to 0.
- Reset mid-transaction: returns to the reset state in the next cycle. imem shares the reset; no pre-reset response is delivered.

Optional Feature:
- Macro FETCH_MISALIGN_CHK_EN.
- Defined:
  - Adds output port misalign_o (1 bit, reset 0).
  - A redirect with redirect_target_i[1:0]!=0 is not followed.
  - misalign_o pulses for 1 cycle in N+1 and flush_o pulses.
  - FSM enters HALT: req = 0, instr_valid_o = 0, and any outstanding response is dropped.
  - HALT is left only by reset.
- Undefined: no port; the target's low 2 bits are forced to 00.

Test Plan:
- Reset release, zero-wait memory, stall_i=0 -> addresses 0,4,8 requested; instr_valid_o carries instr_pc_o 0,4,8, one instruction per 2 cycles; flush_o never asserts.
- stall_i held 5 cycles while instr_valid_o=1 -> instr_o and instr_pc_o stable, imem_req_o=0 throughout; fetch resumes the cycle after stall_i falls.
- branch_taken_i=1, target 32'h0000_0100, while in WAIT with rvalid delayed 3 cycles -> DRAIN, stale response dropped, flush_o pulse, next delivered instr_pc_o=0x100.
- Redirect to 0x200 in the same cycle as rvalid -> that response is never delivered, instr_valid_o=0 next cycle, next request addr 0x200.
- Two back-to-back redirects (0x300 then 0x400) during DRAIN -> only 0x400 is fetched.
- PC at 32'hFFFF_FFFC -> next request addr 0.
- With FETCH_MISALIGN_CHK_EN, jump_i to 0x102 -> misalign_o pulse, no further imem_req_o until reset; without the macro -> fetch at 0x100.
